keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 123 ++++++++++++
 tb/tb_keypad_emulator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 keypad responder: col->row is combinational (zero latency); one press/release per accepted request, key_ready low while busy (no queueing).
// Optional contact bounce at the start of PRESS and RELEASE is enabled by defining KEYEMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES    = 50000,
  parameter int unsigned RELEASE_CYCLES = 50000,
  parameter int unsigned BOUNCE_CYCLES  = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       cancel,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_HR  = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_HR > BOUNCE_CYCLES) ? MAX_HR : BOUNCE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    key_q;
  logic          done_q;
  logic          contact;

  // Counter only ever reaches HOLD_LAST/REL_LAST before clearing, so it cannot wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            key_q   <= key_code;
            cnt_q   <= '0;
            state_q <= PRESS;
          end
        end
        PRESS: begin
          if (cancel || (cnt_q == HOLD_LAST)) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == REL_LAST) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef KEYEMU_BOUNCE_EN
  localparam logic [CW-1:0] BOUNCE_LIM = CW'(BOUNCE_CYCLES);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       in_bounce;

  // Fibonacci LFSR, taps 8,6,5,4.
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign in_bounce = (cnt_q < BOUNCE_LIM);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    contact = 1'b0;
    case (state_q)
      PRESS:   contact = in_bounce ? lfsr_q[0] : 1'b1;
      RELEASE: contact = in_bounce ? lfsr_q[0] : 1'b0;
      default: contact = 1'b0;
    endcase
  end
`else
  assign contact = (state_q == PRESS);
`endif

  always_comb begin
    row = 4'hF;
    if (contact && !col[key_q[1:0]]) begin
      row[key_q[3:2]] = 1'b0;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: reset, press timing, key_valid hold, cancel, mid-press reset and contact bounce.
module tb_keypad_emulator;

  localparam int HOLD   = 20;
  localparam int REL    = 10;
  localparam int BOUNCE = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       cancel = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] row;
  logic       key_ready;
  logic       busy;
  logic       done;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_acc;
  int         n_done;
  logic       got_done;
  logic       closed;
  logic [3:0] exp_row;
  logic [3:0] pat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clock = ~clock;

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .RELEASE_CYCLES(REL),
    .BOUNCE_CYCLES (BOUNCE)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .cancel   (cancel),
    .col      (col),
    .row      (row),
    .key_ready(key_ready),
    .busy     (busy),
    .done     (done)
  );

`ifdef KEYEMU_BOUNCE_EN
  logic [7:0] lfsr_m;
  always @(posedge clock) begin
    if (!reset_n) lfsr_m <= 8'hA5;
    else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge, apply col, let the combinational path settle.
  task automatic step(input logic [3:0] c);
    @(negedge clock);
    col = c;
    #1;
  endtask

  // Present a request in an IDLE cycle; returns settled in PRESS cycle 1.
  task automatic accept(input logic [3:0] code, input logic [3:0] c);
    step(c);
    check("accept_ready", 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_code  = code;
    step(c);
    key_valid = 1'b0;
  endtask

  initial begin
    // Reset overrides simultaneous key_valid and cancel.
    key_valid = 1'b1;
    cancel    = 1'b1;
    key_code  = 4'hF;
    col       = 4'h0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", 32'(key_ready), 32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_row",   32'(row),       32'hF);
    check("rst_done",  32'(done),      32'd0);
    reset_n   = 1'b1;
    key_valid = 1'b0;
    cancel    = 1'b0;
    step(4'hF);
    check("post_rst_ready", 32'(key_ready), 32'd1);

    // Basic press: key 0110 answers only when col = B; done 31 cycles after acceptance.
    accept(4'b0110, pat[1]);
    for (int i = 1; i <= 31; i++) begin
      if (i > 1) step(pat[i % 4]);
      exp_row = (i <= HOLD && col == 4'hB) ? 4'hD : 4'hF;
      check("A_row",  32'(row),  32'(exp_row));
      check("A_done", 32'(done), 32'(i == 31));
      check("A_busy", 32'(busy), 32'(i <= 30));
    end

    // key_valid held: one acceptance per IDLE visit, new press starts right after done.
    step(4'hF);
    key_valid = 1'b1;
    key_code  = 4'b0110;
    n_acc     = 0;
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) step(4'hF);
      if (key_valid && key_ready) n_acc++;
      check("B_busy", 32'(busy), 32'(!(i == 0 || i == 31)));
      check("B_done", 32'(done), 32'(i == 31));
    end
    check("B_accepts", 32'(n_acc), 32'd2);
    key_valid = 1'b0;
    got_done  = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      step(4'hF);
      if (done) got_done = 1'b1;
    end
    check("B_drain_done", 32'(got_done), 32'd1);

    // Cancel at PRESS cycle 5; cancel in RELEASE/IDLE and key_valid while busy are ignored.
    accept(4'b1011, 4'h7);
    for (int i = 1; i <= 18; i++) begin
      if (i > 1) step(4'h7);
      cancel    = (i == 5 || i == 9 || i == 17);
      key_valid = (i == 3);
      key_code  = 4'b0000;
      check("C_row",  32'(row),  (i <= 5) ? 32'hB : 32'hF);
      check("C_busy", 32'(busy), 32'(i <= 15));
      check("C_done", 32'(done), 32'(i == 16));
    end
    cancel    = 1'b0;
    key_valid = 1'b0;

    // Reset at PRESS cycle 8: row released at once, no done pulse.
    accept(4'b0000, 4'hE);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) step(4'hE);
      check("D_row_press", 32'(row), 32'hE);
    end
    reset_n   = 1'b0;
    key_valid = 1'b1;
    cancel    = 1'b1;
    key_code  = 4'hF;
    step(4'hE);
    reset_n   = 1'b1;
    key_valid = 1'b0;
    cancel    = 1'b0;
    check("D_row",   32'(row),       32'hF);
    check("D_ready", 32'(key_ready), 32'd1);
    check("D_busy",  32'(busy),      32'd0);
    check("D_done",  32'(done),      32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      step(4'hE);
      if (done) n_done++;
    end
    check("D_no_done", 32'(n_done), 32'd0);

    // Column held at the key's column: clean contact, or LFSR bounce in the first BOUNCE cycles.
    accept(4'b1101, 4'hD);
    for (int i = 1; i <= 31; i++) begin
      if (i > 1) step(4'hD);
`ifdef KEYEMU_BOUNCE_EN
      if (i <= HOLD)     closed = ((i - 1) < BOUNCE) ? lfsr_m[0] : 1'b1;
      else if (i <= 30)  closed = ((i - 21) < BOUNCE) ? lfsr_m[0] : 1'b0;
      else               closed = 1'b0;
`else
      closed = (i <= HOLD);
`endif
      exp_row = closed ? 4'h7 : 4'hF;
      check("E_row",  32'(row),  32'(exp_row));
      check("E_done", 32'(done), 32'(i == 31));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
